// File: rtl/memctrl_pkg.sv
// memctrl_pkg: request codes, fetch-state encodings and bus widths shared by memctrl
// and its fetch buffer.
package memctrl_pkg;

    localparam int BYTE_W = 8;
    localparam int ADDR_W = 32;
    localparam int INST_W = 32;

    typedef enum logic [1:0] {
        MEM_IDLE  = 2'b00,
        MEM_READ  = 2'b01,
        MEM_WRITE = 2'b10,
        MEM_RSVD  = 2'b11
    } mem_rw_e;

    typedef enum logic [1:0] {
        FS_IDLE = 2'b00,
        FS_RD   = 2'b01,
        FS_LAST = 2'b10
    } fetch_state_e;

    // True when addr falls in the four bytes starting at base, modulo 2^32.
    function automatic logic addr_in_word(input logic [ADDR_W-1:0] addr,
                                          input logic [ADDR_W-1:0] base);
        logic [ADDR_W-1:0] diff;
        diff = addr - base;
        return (diff < 32'd4);
    endfunction

endpackage

// File: rtl/memctrl_fetch_buf.sv
// memctrl_fetch_buf: one-entry instruction buffer (valid, tag, data) for memctrl.
// Present only when MEMCTRL_FETCH_BUF_EN is defined.
`ifdef MEMCTRL_FETCH_BUF_EN
module memctrl_fetch_buf
    import memctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              fill,
    input  logic [ADDR_W-1:0] fill_tag,
    input  logic [INST_W-1:0] fill_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [INST_W-1:0] hit_data
);

    logic              valid_r;
    logic [ADDR_W-1:0] tag_r;
    logic [INST_W-1:0] data_r;
    logic              inval_s;

    // A write landing in the buffered word kills the entry in the same cycle.
    assign inval_s  = wr_en && valid_r && addr_in_word(wr_addr, tag_r);
    assign hit      = valid_r && !inval_s && (lookup_addr == tag_r);
    assign hit_data = data_r;

    // Entry storage: refilled on every completed RAM fetch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= 1'b0;
            tag_r   <= 32'd0;
            data_r  <= 32'd0;
        end else if (fill) begin
            valid_r <= 1'b1;
            tag_r   <= fill_tag;
            data_r  <= fill_data;
        end else if (inval_s) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

endmodule
`endif

// File: rtl/memctrl.sv
// memctrl: single byte-wide RAM shared by a MEM-stage port (combinational, highest
// priority) and a four-byte instruction fetch sequencer. MEMCTRL_FETCH_BUF_EN adds a fetch buffer.
module memctrl
    import memctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        rw_from_mem,
    input  logic [ADDR_W-1:0] addr_from_mem,
    input  logic [BYTE_W-1:0] data_from_mem,
    output logic [BYTE_W-1:0] data_to_mem,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [INST_W-1:0] inst_o,
    output logic              if_done,
    input  logic [BYTE_W-1:0] mem_din,
    output logic [BYTE_W-1:0] mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);

    mem_rw_e                rw_s;
    fetch_state_e           state_r;
    fetch_state_e           state_nxt_s;
    logic [1:0]             k_r;
    logic [2:0][BYTE_W-1:0] bytes_r;
    logic [ADDR_W-1:0]      fetch_addr_r;
    logic [INST_W-1:0]      inst_r;
    logic                   done_r;
    logic                   mem_busy_s;
    logic                   abort_s;
    logic                   accept_s;
    logic                   hit_take_s;
    logic                   capture_s;
    logic                   complete_s;
    logic                   buf_hit_s;
    logic [INST_W-1:0]      buf_data_s;
    logic [INST_W-1:0]      fetch_word_s;

    assign rw_s         = mem_rw_e'(rw_from_mem);
    assign mem_busy_s   = (rw_s == MEM_READ) || (rw_s == MEM_WRITE);
    // Any MEM traffic, a dropped request or a changed target cancels the fetch in flight.
    assign abort_s      = mem_busy_s || !if_req || (if_addr != fetch_addr_r);
    assign hit_take_s   = (state_r == FS_IDLE) && if_req && buf_hit_s;
    assign accept_s     = (state_r == FS_IDLE) && if_req && !mem_busy_s && !hit_take_s;
    assign fetch_word_s = {mem_din, bytes_r[2], bytes_r[1], bytes_r[0]};
    assign data_to_mem  = mem_din;
    assign inst_o       = inst_r;
    assign if_done      = done_r;

`ifdef MEMCTRL_FETCH_BUF_EN
    logic mem_write_s;
    assign mem_write_s = (rw_s == MEM_WRITE);

    memctrl_fetch_buf u_fetch_buf (
        .clk         (clk),
        .rst         (rst),
        .fill        (complete_s),
        .fill_tag    (fetch_addr_r),
        .fill_data   (fetch_word_s),
        .wr_en       (mem_write_s),
        .wr_addr     (addr_from_mem),
        .lookup_addr (if_addr),
        .hit         (buf_hit_s),
        .hit_data    (buf_data_s)
    );
`else
    assign buf_hit_s  = 1'b0;
    assign buf_data_s = 32'd0;
`endif

    // Fetch state and byte counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= FS_IDLE;
            k_r     <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == FS_RD) && (state_nxt_s == FS_RD)) begin
                k_r <= k_r + 2'd1;
            end else begin
                k_r <= 2'd0;
            end
        end
    end

    // Next-state decode for the fetch sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            FS_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = FS_RD;
                end else begin
                    state_nxt_s = FS_IDLE;
                end
            end
            FS_RD: begin
                if (abort_s) begin
                    state_nxt_s = FS_IDLE;
                end else if (k_r == 2'd3) begin
                    state_nxt_s = FS_LAST;
                end else begin
                    state_nxt_s = FS_RD;
                end
            end
            FS_LAST: begin
                state_nxt_s = FS_IDLE;
            end
            default: begin
                state_nxt_s = FS_IDLE;
            end
        endcase
    end

    // RAM port mux (MEM first) and per-cycle capture/complete strobes.
    always_comb begin
        mem_a      = 32'd0;
        mem_dout   = 8'd0;
        mem_wr     = 1'b0;
        capture_s  = 1'b0;
        complete_s = 1'b0;
        case (rw_s)
            MEM_WRITE: begin
                mem_a    = addr_from_mem;
                mem_dout = data_from_mem;
                mem_wr   = 1'b1;
            end
            MEM_READ: begin
                mem_a = addr_from_mem;
            end
            default: begin
                if (state_r == FS_RD) begin
                    mem_a = fetch_addr_r + {30'd0, k_r};
                end else begin
                    mem_a = 32'd0;
                end
            end
        endcase
        if ((state_r == FS_RD) && !abort_s && (k_r != 2'd0)) begin
            capture_s = 1'b1;
        end else begin
            capture_s = 1'b0;
        end
        if ((state_r == FS_LAST) && !abort_s) begin
            complete_s = 1'b1;
        end else begin
            complete_s = 1'b0;
        end
    end

    // Fetch datapath: target latch, byte capture, instruction and done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_addr_r <= 32'd0;
            bytes_r      <= 24'd0;
            inst_r       <= 32'd0;
            done_r       <= 1'b0;
        end else begin
            if (accept_s) begin
                fetch_addr_r <= if_addr;
            end
            if (capture_s) begin
                case (k_r)
                    2'd1:    bytes_r[0] <= mem_din;
                    2'd2:    bytes_r[1] <= mem_din;
                    2'd3:    bytes_r[2] <= mem_din;
                    default: bytes_r    <= bytes_r;
                endcase
            end
            if (complete_s) begin
                inst_r <= fetch_word_s;
            end else if (hit_take_s) begin
                inst_r <= buf_data_s;
            end
            done_r <= complete_s || hit_take_s;
        end
    end

endmodule

// File: tb/tb_memctrl.sv
// tb_memctrl: directed bench for memctrl with a one-cycle-latency byte RAM model.
// Stimulus queues expected per-cycle bus values and fetch results; a monitor compares them.
module tb_memctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rw_from_mem;
    logic [31:0] addr_from_mem;
    logic [7:0]  data_from_mem;
    logic [7:0]  data_to_mem;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] inst_o;
    logic        if_done;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    typedef struct {
        logic [31:0] a;
        logic        wr;
        logic [7:0]  dout;
        logic        dchk;
        logic [7:0]  din;
        logic        done;
    } cyc_t;

    cyc_t        bus_q[$];
    logic [31:0] inst_q[$];
    cyc_t        mon_e;
    int          n_vec  = 0;
    int          n_miss = 0;
    logic [7:0]  ram [0:16383];

    memctrl dut (
        .clk           (clk),
        .rst           (rst),
        .rw_from_mem   (rw_from_mem),
        .addr_from_mem (addr_from_mem),
        .data_from_mem (data_from_mem),
        .data_to_mem   (data_to_mem),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .inst_o        (inst_o),
        .if_done       (if_done),
        .mem_din       (mem_din),
        .mem_dout      (mem_dout),
        .mem_a         (mem_a),
        .mem_wr        (mem_wr)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // RAM model: read data appears one cycle after the address.
    initial begin
        for (int i = 0; i < 16384; i++) ram[i] = 8'h00;
        ram[14'h1000] = 8'h13; ram[14'h1001] = 8'h05;
        ram[14'h1002] = 8'h10; ram[14'h1003] = 8'h00;
        ram[14'h3000] = 8'h5A;
        ram[14'h3FFE] = 8'h11; ram[14'h3FFF] = 8'h22;
        ram[14'h0000] = 8'h33; ram[14'h0001] = 8'h44;
        mem_din = 8'h00;
        forever begin
            @(posedge clk);
            mem_din <= ram[mem_a[13:0]];
            if (mem_wr) ram[mem_a[13:0]] = mem_dout;
        end
    end

    // Monitor: per-cycle bus expectations and fetch results on if_done.
    initial forever begin
        @(negedge clk);
        if (rst && bus_q.size() > 0) begin
            mon_e = bus_q.pop_front();
            chk("mem_a", mem_a, mon_e.a);
            chk("mem_wr", {31'd0, mem_wr}, {31'd0, mon_e.wr});
            if (mon_e.wr || mon_e.a == 32'd0) chk("mem_dout", {24'd0, mem_dout}, {24'd0, mon_e.dout});
            if (mon_e.dchk) chk("data_to_mem", {24'd0, data_to_mem}, {24'd0, mon_e.din});
            chk("if_done", {31'd0, if_done}, {31'd0, mon_e.done});
        end
        if (rst && if_done) begin
            if (inst_q.size() > 0) begin
                chk("inst_o", inst_o, inst_q.pop_front());
            end else begin
                n_vec++;
                n_miss++;
                $display("FAIL if_done_unexpected: got pulse with inst_o=%h, want no pulse (t=%0t)", inst_o, $time);
            end
        end
    end

    task automatic step(input logic [1:0] rw, input logic [31:0] ma, input logic [7:0] md,
                        input logic rq, input logic [31:0] ia,
                        input logic [31:0] ea, input logic ewr, input logic [7:0] ed,
                        input logic dchk, input logic [7:0] din, input logic edone);
        cyc_t c;
        rw_from_mem   = rw;
        addr_from_mem = ma;
        data_from_mem = md;
        if_req        = rq;
        if_addr       = ia;
        c.a = ea; c.wr = ewr; c.dout = ed; c.dchk = dchk; c.din = din; c.done = edone;
        bus_q.push_back(c);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(2'b00, 32'd0, 8'd0, 1'b0, 32'd0, 32'd0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic mem_write(input logic [31:0] a, input logic [7:0] d);
        step(2'b10, a, d, 1'b0, 32'd0, a, 1'b1, d, 1'b0, 8'd0, 1'b0);
    endtask

    // Uninterrupted fetch: accept, four addresses, LAST, then the done cycle.
    task automatic full_fetch(input logic [31:0] fa, input logic [31:0] w);
        inst_q.push_back(w);
        step(2'b00, 32'd0, 8'd0, 1'b1, fa, 32'd0,        1'b0, 8'd0, 1'b0, 8'd0,     1'b0);
        step(2'b00, 32'd0, 8'd0, 1'b1, fa, fa,           1'b0, 8'd0, 1'b0, 8'd0,     1'b0);
        step(2'b00, 32'd0, 8'd0, 1'b1, fa, fa + 32'd1,   1'b0, 8'd0, 1'b1, w[7:0],   1'b0);
        step(2'b00, 32'd0, 8'd0, 1'b1, fa, fa + 32'd2,   1'b0, 8'd0, 1'b1, w[15:8],  1'b0);
        step(2'b00, 32'd0, 8'd0, 1'b1, fa, fa + 32'd3,   1'b0, 8'd0, 1'b1, w[23:16], 1'b0);
        step(2'b00, 32'd0, 8'd0, 1'b1, fa, 32'd0,        1'b0, 8'd0, 1'b1, w[31:24], 1'b0);
        step(2'b00, 32'd0, 8'd0, 1'b0, fa, 32'd0,        1'b0, 8'd0, 1'b0, 8'd0,     1'b1);
    endtask

    initial begin
        rst = 1'b0;
        rw_from_mem = 2'b00; addr_from_mem = 32'd0; data_from_mem = 8'd0;
        if_req = 1'b0; if_addr = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_inst_o", inst_o, 32'h00000000);
        chk("reset_if_done", {31'd0, if_done}, 32'd0);
        chk("reset_mem_a", mem_a, 32'd0);
        chk("reset_mem_wr", {31'd0, mem_wr}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Plain fetch of 0x1000.
        full_fetch(32'h00001000, 32'h00100513);

        // Four MEM writes, read-back, and a reserved code that must stay idle.
        mem_write(32'h00002000, 8'hEF);
        mem_write(32'h00002001, 8'hBE);
        mem_write(32'h00002002, 8'hAD);
        mem_write(32'h00002003, 8'hDE);
        idle(1);
        step(2'b01, 32'h2000, 8'd0, 1'b0, 32'd0, 32'h2000, 1'b0, 8'd0, 1'b0, 8'd0,  1'b0);
        step(2'b01, 32'h2001, 8'd0, 1'b0, 32'd0, 32'h2001, 1'b0, 8'd0, 1'b1, 8'hEF, 1'b0);
        step(2'b01, 32'h2002, 8'd0, 1'b0, 32'd0, 32'h2002, 1'b0, 8'd0, 1'b1, 8'hBE, 1'b0);
        step(2'b01, 32'h2003, 8'd0, 1'b0, 32'd0, 32'h2003, 1'b0, 8'd0, 1'b1, 8'hAD, 1'b0);
        step(2'b11, 32'h2000, 8'h55, 1'b0, 32'd0, 32'd0,   1'b0, 8'd0, 1'b1, 8'hDE, 1'b0);
        chk("ram_word_2000", {ram[14'h2003], ram[14'h2002], ram[14'h2001], ram[14'h2000]}, 32'hDEADBEEF);

        // Fetch preempted by a MEM read at k=2, then restarted; rw=11 must not preempt.
        mem_write(32'h00001003, 8'h00);
        inst_q.push_back(32'h00100513);
        step(2'b00, 32'd0,    8'd0,  1'b1, 32'h1000, 32'd0,    1'b0, 8'd0, 1'b0, 8'd0,  1'b0);
        step(2'b00, 32'd0,    8'd0,  1'b1, 32'h1000, 32'h1000, 1'b0, 8'd0, 1'b0, 8'd0,  1'b0);
        step(2'b00, 32'd0,    8'd0,  1'b1, 32'h1000, 32'h1001, 1'b0, 8'd0, 1'b1, 8'h13, 1'b0);
        step(2'b01, 32'h3000, 8'd0,  1'b1, 32'h1000, 32'h3000, 1'b0, 8'd0, 1'b1, 8'h05, 1'b0);
        step(2'b00, 32'd0,    8'd0,  1'b1, 32'h1000, 32'd0,    1'b0, 8'd0, 1'b1, 8'h5A, 1'b0);
        step(2'b11, 32'h3000, 8'h77, 1'b1, 32'h1000, 32'h1000, 1'b0, 8'd0, 1'b0, 8'd0,  1'b0);
        step(2'b00, 32'd0,    8'd0,  1'b1, 32'h1000, 32'h1001, 1'b0, 8'd0, 1'b1, 8'h13, 1'b0);
        step(2'b00, 32'd0,    8'd0,  1'b1, 32'h1000, 32'h1002, 1'b0, 8'd0, 1'b1, 8'h05, 1'b0);
        step(2'b00, 32'd0,    8'd0,  1'b1, 32'h1000, 32'h1003, 1'b0, 8'd0, 1'b1, 8'h10, 1'b0);
        step(2'b00, 32'd0,    8'd0,  1'b1, 32'h1000, 32'd0,    1'b0, 8'd0, 1'b1, 8'h00, 1'b0);
        step(2'b00, 32'd0,    8'd0,  1'b0, 32'h1000, 32'd0,    1'b0, 8'd0, 1'b0, 8'd0,  1'b1);

        // if_req dropped at k=1: back to idle, no completion, inst_o held.
        mem_write(32'h00001003, 8'h00);
        step(2'b00, 32'd0, 8'd0, 1'b1, 32'h1000, 32'd0,    1'b0, 8'd0, 1'b0, 8'd0,  1'b0);
        step(2'b00, 32'd0, 8'd0, 1'b1, 32'h1000, 32'h1000, 1'b0, 8'd0, 1'b0, 8'd0,  1'b0);
        step(2'b00, 32'd0, 8'd0, 1'b0, 32'h1000, 32'h1001, 1'b0, 8'd0, 1'b1, 8'h13, 1'b0);
        step(2'b00, 32'd0, 8'd0, 1'b0, 32'h1000, 32'd0,    1'b0, 8'd0, 1'b1, 8'h05, 1'b0);
        idle(3);
        chk("drop_inst_hold", inst_o, 32'h00100513);

        // Asynchronous reset in the middle of the k=3 cycle.
        step(2'b00, 32'd0, 8'd0, 1'b1, 32'h1000, 32'd0,    1'b0, 8'd0, 1'b0, 8'd0,  1'b0);
        step(2'b00, 32'd0, 8'd0, 1'b1, 32'h1000, 32'h1000, 1'b0, 8'd0, 1'b0, 8'd0,  1'b0);
        step(2'b00, 32'd0, 8'd0, 1'b1, 32'h1000, 32'h1001, 1'b0, 8'd0, 1'b1, 8'h13, 1'b0);
        step(2'b00, 32'd0, 8'd0, 1'b1, 32'h1000, 32'h1002, 1'b0, 8'd0, 1'b1, 8'h05, 1'b0);
        #1 rst = 1'b0;
        #1;
        chk("midrst_inst_o", inst_o, 32'h00000000);
        chk("midrst_if_done", {31'd0, if_done}, 32'd0);
        chk("midrst_mem_a", mem_a, 32'd0);
        if_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        idle(6);
        chk("postrst_inst_o", inst_o, 32'h00000000);

        // Address wrap across 0xFFFFFFFF.
        full_fetch(32'hFFFFFFFE, 32'h44332211);

`ifdef MEMCTRL_FETCH_BUF_EN
        // Buffer hit with a concurrent MEM read, then invalidation by a write into the word.
        full_fetch(32'h00001000, 32'h00100513);
        inst_q.push_back(32'h00100513);
        step(2'b01, 32'h3000, 8'd0, 1'b1, 32'h1000, 32'h3000, 1'b0, 8'd0, 1'b0, 8'd0,  1'b0);
        step(2'b00, 32'd0,    8'd0, 1'b0, 32'h1000, 32'd0,    1'b0, 8'd0, 1'b1, 8'h5A, 1'b1);
        mem_write(32'h00001002, 8'h10);
        full_fetch(32'h00001000, 32'h00100513);
`endif

        idle(3);
        chk("inst_q_drained", 32'(inst_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/memctrl.md
MEMCTRL -- requirements
Module: memctrl

Interface
REQ-001 SHALL have these ports: clk  in  1  clock, all state on rising edge.
REQ-002 SHALL have these ports: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have these ports: rw_from_mem  in  2  MEM-stage request: 00 idle, 01 read byte, 10 write byte, 11 reserved.
REQ-004 SHALL have these ports: addr_from_mem  in  32  MEM byte address.
REQ-005 SHALL have these ports: data_from_mem  in  8  MEM write byte.
REQ-006 SHALL have these ports: data_to_mem  out  8  MEM read byte.
REQ-007 SHALL have these ports: if_req  in  1  instruction fetch request, level.
REQ-008 SHALL have these ports: if_addr  in  32  fetch word address.
REQ-009 SHALL have these ports: inst_o  out  32  fetched instruction, little-endian.
REQ-010 SHALL have these ports: if_done  out  1  one-cycle fetch-complete pulse.
REQ-011 SHALL have these ports: mem_din  in  8  RAM read data, valid one cycle after address.
REQ-012 SHALL have these ports: mem_dout  out  8  RAM write data.
REQ-013 SHALL have these ports: mem_a  out  32  RAM address.
REQ-014 SHALL have these ports: mem_wr  out  1  RAM write enable.

Function
REQ-015 SHALL treat the MEM port as a combinational pass-through with priority over fetch.
- rw=10: mem_a=addr_from_mem, mem_dout=data_from_mem, mem_wr=1 in the same cycle.
- rw=01: mem_a=addr_from_mem, mem_wr=0.
REQ-016 SHALL drive data_to_mem=mem_din combinationally in every cycle, so MEM samples a read byte two edges after registering its request.
REQ-017 SHALL treat rw=11 as idle: no RAM access and no preemption.
REQ-018 SHALL implement the fetch FSM with states IDLE, RD (2-bit counter k=0..3) and LAST.
REQ-019 SHALL leave IDLE for RD (k=0) at an edge where if_req=1 and rw_from_mem is 00 or 11, latching if_addr as fetch_addr (the accepting edge E0).
REQ-020 SHALL drive mem_a=fetch_addr+k and mem_wr=0 in RD; for k>0, capture mem_din as byte k-1; k increments each cycle; k=3 goes to LAST.
REQ-021 SHALL capture byte 3 in LAST, then at the next edge (E5) load inst_o={b3,b2,b1,b0}, set if_done=1 for exactly one cycle, and return to IDLE.
REQ-022 SHALL abort to IDLE, with no if_done and inst_o unchanged, in any RD/LAST cycle where rw_from_mem is 01/10, if_req=0, or if_addr!=fetch_addr; a still-pending if_req restarts from byte 0.
REQ-023 SHALL drive mem_a=0, mem_dout=0, mem_wr=0 when neither the MEM port nor the fetch FSM uses RAM.
REQ-024 SHALL compute address additions modulo 2^32, with 0xFFFFFFFF+1 wrapping to 0.
REQ-025 SHALL let an if_req that arrives together with a MEM request wait; the MEM request is always served first.

Reset
REQ-026 SHALL, when rst=0, immediately and asynchronously set: FSM=IDLE, k=0, captured bytes=0, fetch_addr=0, inst_o=0x00000000, if_done=0, buffer invalid.
REQ-027 SHALL, when reset is asserted mid-fetch, discard the fetch with no if_done; operation resumes at the first edge after rst=1.

Configuration
REQ-028 SHALL, with MEMCTRL_FETCH_BUF_EN defined, keep a one-entry fetch buffer (valid, 32-bit tag, 32-bit data).
- Written on every completed fetch.
- In IDLE, if_req with valid && if_addr==tag gives inst_o=data and if_done=1 at the next edge, with no RAM access, independent of the MEM port.
- Any MEM write with addr_from_mem in [tag, tag+3] clears valid in that cycle.
REQ-029 SHALL, without MEMCTRL_FETCH_BUF_EN, contain no buffer logic; every fetch follows REQ-019..REQ-021.

Structure
REQ-030 SHALL take the following from the shared defines file:
- rw codes `MemIdle/`MemRead/`MemWrite.
- fetch-state encodings.
- `ByteBus, `DataAddrBus, `InstBus widths.
REQ-031 SHALL implement the buffer as sub-module memctrl_fetch_buf, instantiated only under MEMCTRL_FETCH_BUF_EN.

Verification
REQ-032 SHALL cover: RAM[0x1000..0x1003]=13,05,10,00; if_req, if_addr=0x1000 -> mem_a 0x1000..0x1003 on consecutive cycles; inst_o=0x00100513; if_done single-cycle at E5.
REQ-033 SHALL cover: rw=10 for four cycles, addr 0x2000..0x2003, data EF,BE,AD,DE -> same-cycle mem_wr=1, mem_a/mem_dout match; RAM word 0xDEADBEEF.
REQ-034 SHALL cover: fetch 0x1000 preempted by rw=01 to 0x3000 (RAM=0x5A) during k=2 -> mem_a=0x3000 that cycle; data_to_mem=0x5A next cycle; fetch restarts; inst_o=0x00100513 six cycles after restart edge.
REQ-035 SHALL cover: if_req dropped during k=1 -> IDLE next edge; no if_done; inst_o unchanged.
REQ-036 SHALL cover: rst=0 asserted mid-cycle during k=3 -> inst_o=0 and if_done=0 without a clock edge; no completion afterwards.
REQ-037 SHALL cover, with MEMCTRL_FETCH_BUF_EN: refetch 0x1000 -> if_done at E1, no RAM access; after MEM write to 0x1002, refetch -> full RAM fetch.
